arbitro_qos: RTL and testbench

//  Parametrised QoS arbiter between the ingress FIFO and NUM_CH per-class egress FIFOs.

---
 rtl/arbitro_qos_pkg.sv | 7 +
 rtl/arbitro_qos_sat_counter.sv | 13 +
 rtl/arbitro_qos.sv | 88 ++++++++
 tb/tb_arbitro_qos.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/arbitro_qos_pkg.sv
// arbitro_qos_pkg: shared widths and FSM encoding for the QoS arbiter and its FIFO/demux neighbours
package arbitro_qos_pkg;
   localparam int QOS_DATA_W  = 12;
   localparam int QOS_CLASS_W = 2;
   localparam int QOS_CNT_W   = 8;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STALL = 2'd2} state_t;
endpackage

// File: rtl/arbitro_qos_sat_counter.sv
// qos_sat_counter: statistics counter that sticks at all-ones instead of wrapping
module qos_sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);
   always_ff @(posedge clk or negedge reset)
      if (!reset) count <= '0;
      else if (inc && count != '1) count <= count + 1'b1;
endmodule

// File: rtl/arbitro_qos.sv
// arbitro_qos: pops the ingress FIFO and steers each word to its class's egress FIFO,
// holding only a word whose own target is almost full; zero words are counted and dropped
module arbitro_qos
   import arbitro_qos_pkg::*;
#(
   parameter int DATA_W  = QOS_DATA_W,
   parameter int CLASS_W = QOS_CLASS_W,
   parameter int NUM_CH  = 2 ** CLASS_W,
   parameter int CNT_W   = QOS_CNT_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               active,
   input  logic               fifo_empty,
   input  logic [DATA_W-1:0]  fifo_data,
   input  logic [NUM_CH-1:0]  almost_full,
   output logic               pop,
   output logic [NUM_CH-1:0]  push,
   output logic [DATA_W-1:0]  data_out,
   input  logic [CLASS_W:0]   cnt_sel,
   output logic [CNT_W-1:0]   cnt_out,
   output logic               idle
);
   localparam logic [CLASS_W:0] SEL_MAX = (CLASS_W + 1)'(NUM_CH);
   state_t state, state_nx;
   logic rd_valid, hold_valid, blocked, drop, latch;
   logic [DATA_W-1:0] hold;
   logic [CLASS_W-1:0] rd_cls, hold_cls;
   logic [CNT_W-1:0] cnts [0:NUM_CH];

   assign rd_cls   = fifo_data[DATA_W-1 -: CLASS_W];
   assign hold_cls = hold[DATA_W-1 -: CLASS_W];
   assign blocked  = rd_valid && fifo_data != '0 && almost_full[rd_cls];
   assign idle     = state == IDLE;
   assign cnt_out  = (cnt_sel <= SEL_MAX) ? cnts[cnt_sel] : '0;

   always_comb begin
      state_nx = state;
      pop      = 1'b0;
      push     = '0;
      data_out = '0;
      drop     = 1'b0;
      latch    = 1'b0;
      case (state)
         IDLE: state_nx = active ? RUN : IDLE;
         RUN: begin
            pop   = active && !fifo_empty && !blocked;
            drop  = rd_valid && fifo_data == '0;
            latch = blocked;
            if (rd_valid && fifo_data != '0 && !blocked) begin
               push[rd_cls] = 1'b1;
               data_out     = fifo_data;
            end
            state_nx = blocked ? STALL : (!active && !rd_valid) ? IDLE : RUN;
         end
         STALL: if (hold_valid && !almost_full[hold_cls]) begin
            push[hold_cls] = 1'b1;
            data_out       = hold;
            state_nx       = active ? RUN : IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state      <= IDLE;
         rd_valid   <= 1'b0;
         hold_valid <= 1'b0;
         hold       <= '0;
      end else begin
         state    <= state_nx;
         rd_valid <= pop;
         if (latch) begin
            hold       <= fifo_data;
            hold_valid <= 1'b1;
         end else if (state == STALL && push != '0) hold_valid <= 1'b0;
      end

   // one counter per class plus the drop counter in the last slot
   for (genvar c = 0; c <= NUM_CH; c++) begin : g_cnt
      if (c < NUM_CH) begin : g_cls
         qos_sat_counter #(.CNT_W(CNT_W)) u_cnt (.clk(clk), .reset(reset), .inc(push[c]), .count(cnts[c]));
      end else begin : g_drop
         qos_sat_counter #(.CNT_W(CNT_W)) u_cnt (.clk(clk), .reset(reset), .inc(drop), .count(cnts[c]));
      end
   end
endmodule

// File: tb/tb_arbitro_qos.sv
// tb_arbitro_qos: directed table plus randomized traffic against an ordered-delivery model,
// and a narrow-counter instance for saturation
module tb_arbitro_qos;
   logic clk = 1'b0;
   logic reset, active, fifo_empty, pop, idle;
   logic [11:0] fifo_data, dout;
   logic [3:0] af, push;
   logic [2:0] sel;
   logic [7:0] cnt;
   logic reset1, active1, fifo_empty1, pop1, idle1;
   logic [11:0] fifo_data1, dout1;
   logic [7:0] af1, push1;
   logic [3:0] sel1;
   logic [1:0] cnt1;

   int n_chk = 0, n_fail = 0;
   logic [11:0] q[$];
   logic [11:0] expq[$];
   int ecnt[4];
   int edrop;
   logic s_pop, s_idle;
   logic [3:0] s_push, s_af;
   logic [11:0] s_dout;

   typedef struct {
      logic [3:0]  af;
      logic        pop;
      logic [3:0]  push;
      logic [11:0] dout;
   } vec_t;
   vec_t tbl[14];

   arbitro_qos dut (
      .clk(clk), .reset(reset), .active(active), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
      .almost_full(af), .pop(pop), .push(push), .data_out(dout), .cnt_sel(sel), .cnt_out(cnt), .idle(idle)
   );

   arbitro_qos #(.DATA_W(12), .CLASS_W(3), .NUM_CH(8), .CNT_W(2)) dut8 (
      .clk(clk), .reset(reset1), .active(active1), .fifo_empty(fifo_empty1), .fifo_data(fifo_data1),
      .almost_full(af1), .pop(pop1), .push(push1), .data_out(dout1), .cnt_sel(sel1), .cnt_out(cnt1), .idle(idle1)
   );

   initial forever #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // one clock starting at a falling edge; the ingress FIFO model answers a pop one cycle later
   task automatic cyc();
      fifo_empty = (q.size() == 0);
      #1;
      s_pop = pop; s_push = push; s_dout = dout; s_idle = idle; s_af = af;
      @(posedge clk);
      #1;
      if (s_pop && q.size() != 0) fifo_data = q.pop_front();
      @(negedge clk);
   endtask

   task automatic rd_cnt(input string nm, input int s, input int exp);
      sel = 3'(s);
      #1;
      chk(nm, 32'(cnt), 32'(exp > 255 ? 255 : exp));
   endtask

   task automatic check_push();
      logic [11:0] w;
      if (s_push != 0) begin
         chk("rnd_onehot", $countones(s_push), 1);
         chk("rnd_af_respected", 32'(s_push & s_af), 0);
         if (expq.size() == 0) chk("rnd_extra_push", 32'(s_dout), 0);
         else begin
            w = expq.pop_front();
            chk("rnd_data", 32'(s_dout), 32'(w));
            chk("rnd_class", 32'(s_push), 32'(4'b0001 << w[11:10]));
         end
      end else chk("rnd_dout_zero", 32'(s_dout), 0);
   endtask

   initial begin
      logic [11:0] w;
      logic [31:0] r;
      int pops1, n6, other, k;
      tbl[0]  = '{4'h0, 1'b0, 4'h0, 12'h000};
      tbl[1]  = '{4'h0, 1'b1, 4'h0, 12'h000};
      tbl[2]  = '{4'h0, 1'b1, 4'h1, 12'h001};
      tbl[3]  = '{4'h0, 1'b1, 4'h2, 12'h402};
      tbl[4]  = '{4'h0, 1'b1, 4'h4, 12'h803};
      tbl[5]  = '{4'h0, 1'b1, 4'h8, 12'hC04};
      tbl[6]  = '{4'h4, 1'b0, 4'h0, 12'h000};
      tbl[7]  = '{4'h4, 1'b0, 4'h0, 12'h000};
      tbl[8]  = '{4'h4, 1'b0, 4'h0, 12'h000};
      tbl[9]  = '{4'h0, 1'b0, 4'h4, 12'h805};
      tbl[10] = '{4'h0, 1'b1, 4'h0, 12'h000};
      tbl[11] = '{4'h0, 1'b1, 4'h0, 12'h000};
      tbl[12] = '{4'h0, 1'b0, 4'h1, 12'h007};
      tbl[13] = '{4'h0, 1'b0, 4'h0, 12'h000};
      reset = 1'b0; active = 1'b1; af = '0; sel = '0; fifo_data = '0;
      reset1 = 1'b0; active1 = 1'b1; af1 = '0; sel1 = '0; fifo_data1 = 12'hC01; fifo_empty1 = 1'b1;
      q = {12'h001, 12'h402, 12'h803, 12'hC04, 12'h805, 12'h000, 12'h007};
      fifo_empty = 1'b0;
      #2;
      chk("rst_pop", 32'(pop), 0);
      chk("rst_push", 32'(push), 0);
      chk("rst_idle", 32'(idle), 1);
      chk("rst_dout", 32'(dout), 0);
      chk("rst_cnt", 32'(cnt), 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 14; i++) begin
         af = tbl[i].af;
         cyc();
         chk($sformatf("tbl%0d_pop", i), 32'(s_pop), 32'(tbl[i].pop));
         chk($sformatf("tbl%0d_push", i), 32'(s_push), 32'(tbl[i].push));
         chk($sformatf("tbl%0d_dout", i), 32'(s_dout), 32'(tbl[i].dout));
      end
      rd_cnt("cnt_cls0", 0, 2);
      rd_cnt("cnt_cls1", 1, 1);
      rd_cnt("cnt_cls2", 2, 2);
      rd_cnt("cnt_cls3", 3, 1);
      rd_cnt("cnt_drop", 4, 1);
      rd_cnt("cnt_sel5", 5, 0);
      rd_cnt("cnt_sel7", 7, 0);

      q.push_back(12'h403);
      cyc();
      chk("actfall_pop", 32'(s_pop), 1);
      active = 1'b0;
      cyc();
      chk("actfall_push", 32'(s_push), 32'h2);
      chk("actfall_dout", 32'(s_dout), 32'h403);
      chk("actfall_nopop", 32'(s_pop), 0);
      for (k = 0; k < 5 && !s_idle; k++) cyc();
      chk("actfall_idle", 32'(s_idle), 1);

      active = 1'b1; af = 4'b1000;
      q.push_back(12'hC09);
      cyc();
      cyc();
      cyc();
      chk("stall_enter_push", 32'(s_push), 0);
      reset = 1'b0;
      #1;
      chk("rst_stall_push", 32'(push), 0);
      chk("rst_stall_idle", 32'(idle), 1);
      chk("rst_stall_pop", 32'(pop), 0);
      @(negedge clk);
      reset = 1'b1; af = '0;
      for (int i = 0; i < 4; i++) begin
         cyc();
         chk("rst_stall_discard", 32'(s_push), 0);
      end
      rd_cnt("rst_cnt_cls3", 3, 0);
      rd_cnt("rst_cnt_drop", 4, 0);

      // randomized traffic: words must leave in arrival order, zero words only counted
      edrop = 0;
      for (int c = 0; c < 4; c++) ecnt[c] = 0;
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 1) == 1) begin
            w = ($urandom_range(0, 4) == 0) ? 12'h000 : 12'($urandom);
            q.push_back(w);
            if (w == 0) edrop++;
            else begin
               expq.push_back(w);
               ecnt[w[11:10]]++;
            end
         end
         active = ($urandom_range(0, 7) != 0);
         r = $urandom & $urandom;
         af = af ^ r[3:0];
         cyc();
         check_push();
      end
      af = '0; active = 1'b1;
      for (k = 0; k < 400 && (q.size() != 0 || expq.size() != 0); k++) begin
         cyc();
         check_push();
      end
      chk("rnd_drain", 32'(q.size() + expq.size()), 0);
      active = 1'b0;
      for (k = 0; k < 6 && !s_idle; k++) begin
         cyc();
         check_push();
      end
      chk("rnd_idle", 32'(s_idle), 1);
      for (int c = 0; c < 4; c++) rd_cnt($sformatf("rnd_cnt%0d", c), c, ecnt[c]);
      rd_cnt("rnd_drop", 4, edrop);
      rd_cnt("rnd_sel6", 6, 0);

      // eight-class instance with 2-bit counters
      pops1 = 0; n6 = 0; other = 0;
      reset1 = 1'b1;
      for (int i = 0; i < 12; i++) begin
         fifo_empty1 = (pops1 >= 5);
         #1;
         if (pop1) pops1++;
         if (push1[6]) begin
            n6++;
            chk("c6_dout", 32'(dout1), 32'hC01);
         end
         if ((push1 & 8'hBF) != 0) other++;
         @(negedge clk);
      end
      chk("c6_pops", pops1, 5);
      chk("c6_pushes", n6, 5);
      chk("c6_other", other, 0);
      sel1 = 4'd6;
      #1;
      chk("c6_sat", 32'(cnt1), 3);
      sel1 = 4'd8;
      #1;
      chk("c6_drop", 32'(cnt1), 0);
      sel1 = 4'd9;
      #1;
      chk("c6_sel_oob", 32'(cnt1), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
